video_shifter: RTL

Consumer end of the video timer's fetch interface, running in the clk8 domain. Captures each 16-bit screen-buffer word fetched on a loadPixels strobe and serialises it as 4 Mac pixels per clk8 (4 phases per word, MSB first). Aligns blanking and sync with the pixel data and flags fetch underrun/overrun. Output nibble feeds the 4:1 pixel serialiser / horizontal doubler at the VGA pixel clock.

---
 rtl/video_shifter_if.sv | 27 ++
 rtl/video_shifter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/video_shifter_if.sv
// Fetch-side bundle between the video timer (master) and the pixel shifter (slave).
// Carries the word strobe, blanking/sync inputs and the serialised pixel outputs.
interface video_shifter_if;
  logic        loadPixels;
  logic [15:0] dataIn;
  logic        _hblank;
  logic        _vblank;
  logic        hsyncIn;
  logic        vsyncIn;
  logic        clearFlags;
  logic [3:0]  pixelOut;
  logic        videoActive;
  logic        hsyncOut;
  logic        vsyncOut;
  logic        underrun;
  logic        overrun;

  modport master (
    output loadPixels, dataIn, _hblank, _vblank, hsyncIn, vsyncIn, clearFlags,
    input  pixelOut, videoActive, hsyncOut, vsyncOut, underrun, overrun
  );

  modport slave (
    input  loadPixels, dataIn, _hblank, _vblank, hsyncIn, vsyncIn, clearFlags,
    output pixelOut, videoActive, hsyncOut, vsyncOut, underrun, overrun
  );
endinterface

// File: rtl/video_shifter.sv
// Serialises 16-bit screen words into 4-pixel nibbles per clk8, with a one-word
// holding register, blank/sync alignment and sticky underrun/overrun flags.
module video_shifter #(
  parameter bit BLACK_IS_ONE = 1'b1,
  parameter int SYNC_DELAY   = 1
) (
  input  logic            clk8,
  input  logic            reset,
  video_shifter_if.slave  bus
);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t      state_q;
  logic [15:0] shift_q;
  logic [15:0] hold_q;
  logic        hold_valid_q;
  logic [1:0]  phase_q;
  logic [3:0]  pixel_q;
  logic        active_q;
  logic        underrun_q;
  logic        overrun_q;

  logic [15:0] word_d;
  logic        visible_d;
  logic        underrun_set_d;
  logic        overrun_set_d;
  logic        underrun_d;
  logic        overrun_d;
  logic [3:0]  pixel_d;

  assign word_d         = BLACK_IS_ONE ? bus.dataIn : ~bus.dataIn;
  assign visible_d      = bus._hblank & bus._vblank;
  assign underrun_set_d = visible_d && (state_q == EMPTY);
  assign overrun_set_d  = bus.loadPixels && (state_q == SHIFT) &&
                          (phase_q != 2'd3) && hold_valid_q;

  // A set in the same cycle as clearFlags must survive the clear.
  assign underrun_d = underrun_set_d | (underrun_q & ~bus.clearFlags);
  assign overrun_d  = overrun_set_d  | (overrun_q  & ~bus.clearFlags);
  assign pixel_d    = (visible_d && (state_q == SHIFT)) ? shift_q[15:12] : 4'h0;

  always_ff @(posedge clk8 or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      shift_q      <= 16'h0000;
      hold_q       <= 16'h0000;
      hold_valid_q <= 1'b0;
      phase_q      <= 2'd0;
      pixel_q      <= 4'h0;
      active_q     <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      active_q   <= visible_d;
      pixel_q    <= pixel_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
      case (state_q)
        EMPTY: begin
          if (bus.loadPixels) begin
            shift_q <= word_d;
            phase_q <= 2'd0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          phase_q <= phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            // A fresh word on the last phase bypasses the holding register.
            if (bus.loadPixels) begin
              shift_q <= word_d;
            end else if (hold_valid_q) begin
              shift_q      <= hold_q;
              hold_valid_q <= 1'b0;
            end else begin
              shift_q <= shift_q << 4;
              state_q <= EMPTY;
            end
          end else begin
            shift_q <= shift_q << 4;
            if (bus.loadPixels && !hold_valid_q) begin
              hold_q       <= word_d;
              hold_valid_q <= 1'b1;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign bus.pixelOut    = pixel_q;
  assign bus.videoActive = active_q;
  assign bus.underrun    = underrun_q;
  assign bus.overrun     = overrun_q;

  generate
    if (SYNC_DELAY == 0) begin : g_sync_pass
      assign bus.hsyncOut = bus.hsyncIn;
      assign bus.vsyncOut = bus.vsyncIn;
    end else begin : g_sync_dly
      logic [SYNC_DELAY-1:0] hs_q;
      logic [SYNC_DELAY-1:0] vs_q;

      always_ff @(posedge clk8 or posedge reset) begin
        if (reset) begin
          hs_q <= '1;
          vs_q <= '1;
        end else begin
          hs_q[0] <= bus.hsyncIn;
          vs_q[0] <= bus.vsyncIn;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_q[i] <= hs_q[i-1];
            vs_q[i] <= vs_q[i-1];
          end
        end
      end

      assign bus.hsyncOut = hs_q[SYNC_DELAY-1];
      assign bus.vsyncOut = vs_q[SYNC_DELAY-1];
    end
  endgenerate

endmodule
